// File: rtl/lmsm_pkg.sv
// Shared types and widths for the LM/SM register-list sequencer.
package lmsm_pkg;

    localparam int unsigned LMSM_MASK_W = 8;
    localparam int unsigned LMSM_SEL_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_DONE = 2'd2
    } lmsm_state_t;

endpackage

// File: rtl/priority_encoder.sv
// Lowest-set-bit encoder; the index is 0 for an all-zero mask, which callers never rely on.
module priority_encoder #(
    parameter int unsigned W     = 8,
    parameter int unsigned SEL_W = 3
) (
    input  logic [W-1:0]     mask,
    output logic [SEL_W-1:0] idx
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (mask[i]) idx = SEL_W'(i);
        end
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// Load/store-multiple sequencer: walks the latched register list bit 0 upward, one transfer per step.
// Optional base-register writeback port pair enabled by LMSM_ADDR_WRITEBACK_EN.
module lmsm_sequencer
    import lmsm_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned STRIDE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   is_store,
    input  logic [LMSM_MASK_W-1:0] imm8,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic                   mem_ready,
    output logic                   busy,
    output logic                   step_valid,
    output logic [LMSM_SEL_W-1:0]  reg_sel,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   reg_wr_en,
    output logic                   mem_wr_en,
    output logic                   done
`ifdef LMSM_ADDR_WRITEBACK_EN
    ,
    output logic                   wb_en,
    output logic [ADDR_W-1:0]      wb_addr
`endif
);

    lmsm_state_t            state_q, state_d;
    logic [LMSM_MASK_W-1:0] mask_q, mask_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   is_store_q, is_store_d;
    logic [LMSM_SEL_W-1:0]  enc_idx;

    priority_encoder #(
        .W     (LMSM_MASK_W),
        .SEL_W (LMSM_SEL_W)
    ) u_enc (
        .mask (mask_q),
        .idx  (enc_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            addr_q     <= '0;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            addr_q     <= addr_d;
            is_store_q <= is_store_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        addr_d     = addr_q;
        is_store_d = is_store_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d     = imm8;
                    addr_d     = base_addr;
                    is_store_d = is_store;
                    state_d    = (imm8 != '0) ? ST_STEP : ST_DONE;
                end
            end
            ST_STEP: begin
                // A stalled step leaves every register, and so every output, untouched.
                if (mem_ready) begin
                    mask_d[enc_idx] = 1'b0;
                    addr_d          = addr_q + ADDR_W'(STRIDE);
                    if (mask_d == '0) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode registered state only, apart from reg_wr_en which also follows mem_ready.
    assign busy       = (state_q != ST_IDLE);
    assign step_valid = (state_q == ST_STEP);
    assign done       = (state_q == ST_DONE);
    assign reg_sel    = step_valid ? enc_idx : '0;
    assign mem_addr   = step_valid ? addr_q : '0;
    assign reg_wr_en  = step_valid & mem_ready & ~is_store_q;
    assign mem_wr_en  = step_valid & is_store_q;

`ifdef LMSM_ADDR_WRITEBACK_EN
    assign wb_en   = done;
    assign wb_addr = done ? addr_q : '0;
`endif

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Self-checking bench for lmsm_sequencer: directed scenarios plus randomized instructions vs a list model.
module tb_lmsm_sequencer;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned STRIDE = 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              is_store;
    logic [7:0]        imm8;
    logic [ADDR_W-1:0] base_addr;
    logic              mem_ready;
    logic              busy;
    logic              step_valid;
    logic [2:0]        reg_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic              reg_wr_en;
    logic              mem_wr_en;
    logic              done;
`ifdef LMSM_ADDR_WRITEBACK_EN
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
`endif

    int checks = 0;
    int errors = 0;

    lmsm_sequencer #(
        .ADDR_W (ADDR_W),
        .STRIDE (STRIDE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .imm8       (imm8),
        .base_addr  (base_addr),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .step_valid (step_valid),
        .reg_sel    (reg_sel),
        .mem_addr   (mem_addr),
        .reg_wr_en  (reg_wr_en),
        .mem_wr_en  (mem_wr_en),
        .done       (done)
`ifdef LMSM_ADDR_WRITEBACK_EN
        ,
        .wb_en      (wb_en),
        .wb_addr    (wb_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},       32'(busy),       32'd0);
        check({tag, ".step_valid"}, 32'(step_valid), 32'd0);
        check({tag, ".reg_sel"},    32'(reg_sel),    32'd0);
        check({tag, ".mem_addr"},   32'(mem_addr),   32'd0);
        check({tag, ".reg_wr_en"},  32'(reg_wr_en),  32'd0);
        check({tag, ".mem_wr_en"},  32'(mem_wr_en),  32'd0);
        check({tag, ".done"},       32'(done),       32'd0);
`ifdef LMSM_ADDR_WRITEBACK_EN
        check({tag, ".wb_en"},      32'(wb_en),      32'd0);
        check({tag, ".wb_addr"},    32'(wb_addr),    32'd0);
`endif
    endtask

    // mode 0: mem_ready always high; 1: random with bounded stalls; 2: 3 stall cycles per transfer.
    // Modes 1 and 2 also toggle start and scramble the instruction inputs while busy.
    task automatic run_instr(input logic [7:0] imm, input logic [ADDR_W-1:0] base,
                             input logic st, input int mode, input string tag);
        int regs[$];
        int n;
        logic rdy;
        logic [ADDR_W-1:0] exp_addr;
        for (int k = 0; k < 8; k++) if (imm[k]) regs.push_back(k);
        n = regs.size();

        start = 1'b1; imm8 = imm; base_addr = base; is_store = st;
        mem_ready = 1'b1;
        #1;
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".idle_done"}, 32'(done), 32'd0);
        @(negedge clk);

        for (int j = 0; j < n; j++) begin
            int stalls = 0;
            bit acc = 1'b0;
            exp_addr = ADDR_W'(32'(base) + j * STRIDE);
            while (!acc) begin
                case (mode)
                    0:       rdy = 1'b1;
                    2:       rdy = (stalls >= 3);
                    default: rdy = (stalls >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
                endcase
                mem_ready = rdy;
                if (mode != 0) begin
                    start = 1'($urandom_range(0, 1)); imm8 = 8'($urandom);
                    base_addr = ADDR_W'($urandom); is_store = 1'($urandom_range(0, 1));
                end else begin
                    start = 1'b0;
                end
                #1;
                check({tag, ".step_valid"}, 32'(step_valid), 32'd1);
                check({tag, ".busy"},       32'(busy),       32'd1);
                check({tag, ".done"},       32'(done),       32'd0);
                check({tag, ".reg_sel"},    32'(reg_sel),    32'(regs[j]));
                check({tag, ".mem_addr"},   32'(mem_addr),   32'(exp_addr));
                check({tag, ".reg_wr_en"},  32'(reg_wr_en),  32'(rdy & ~st));
                check({tag, ".mem_wr_en"},  32'(mem_wr_en),  32'(st));
                acc = rdy;
                stalls++;
                @(negedge clk);
            end
        end

        mem_ready = 1'($urandom_range(0, 1));
        #1;
        check({tag, ".done_pulse"}, 32'(done),       32'd1);
        check({tag, ".done_busy"},  32'(busy),       32'd1);
        check({tag, ".done_sv"},    32'(step_valid), 32'd0);
        check({tag, ".done_rwe"},   32'(reg_wr_en),  32'd0);
        check({tag, ".done_mwe"},   32'(mem_wr_en),  32'd0);
`ifdef LMSM_ADDR_WRITEBACK_EN
        check({tag, ".wb_en"},   32'(wb_en),   32'd1);
        check({tag, ".wb_addr"}, 32'(wb_addr), 32'(ADDR_W'(32'(base) + n * STRIDE)));
`endif
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; imm8 = '0; base_addr = '0; mem_ready = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all_zero("post_reset");
        @(negedge clk);

        run_instr(8'b1010_0101, 16'h0100, 1'b0, 0, "lm_a5");
        run_instr(8'h80,        16'h0040, 1'b1, 2, "sm_stall");
        run_instr(8'h00,        16'h1234, 1'b0, 0, "zero_mask");
        run_instr(8'h0F,        16'hFFFE, 1'b0, 0, "wrap");

        // Reset during the third transfer of a full-mask load.
        start = 1'b1; imm8 = 8'hFF; base_addr = 16'h0200; is_store = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_mid.reg_sel",  32'(reg_sel),  32'd2);
        check("rst_mid.mem_addr", 32'(mem_addr), 32'h0202);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid.asserted");
        @(negedge clk);
        check_all_zero("rst_mid.held");
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("rst_mid.after_busy", 32'(busy), 32'd0);
            check("rst_mid.after_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        run_instr(8'b0100_1010, 16'h0300, 1'b1, 0, "after_rst");

        for (int t = 0; t < 24; t++) begin
            run_instr(8'($urandom), ADDR_W'($urandom), 1'($urandom_range(0, 1)), 1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Multi-cycle sequencer for the load-multiple / store-multiple (LM/SM) instructions. It latches the 8-bit register-list immediate and a base address, then walks the set bits from bit 0 upward. Each walk step is one memory transfer: a register select, a memory address and the write-enables the datapath needs. It sits between the controller FSM (which issues `start`) and the register-file/memory ports, and it drives the existing `priority_encoder` with its live mask.

## Interface
- `ADDR_W`, 16: memory address width.
- `STRIDE`, 1: address increment per transfer, in words.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin an instruction; sampled only in IDLE.
- `is_store` input 1: 0 = LM (memory→reg), 1 = SM (reg→memory); latched with `start`.
- `imm8` input 8: register list; bit k selects R k.
- `base_addr` input ADDR_W: address of the first transfer.
- `mem_ready` input 1: memory accepts/returns the current transfer this cycle.
- `busy` output 1: high in STEP and DONE.
- `step_valid` output 1: a transfer is presented this cycle (STEP only).
- `reg_sel` output 3: register index of the current transfer.
- `mem_addr` output ADDR_W: address of the current transfer.
- `reg_wr_en` output 1: `step_valid & mem_ready & ~is_store_q`.
- `mem_wr_en` output 1: `step_valid & ~... ` → exactly `step_valid & is_store_q`.
- `done` output 1: one-cycle completion pulse.
- `wb_en` output 1, `wb_addr` output ADDR_W: present only with `LMSM_ADDR_WRITEBACK_EN`.

## Operation
- States: IDLE, STEP, DONE. Registers: `mask_q[7:0]`, `addr_q`, `is_store_q`, state.
- IDLE:
  - If `start`=1, latch `imm8`, `base_addr` and `is_store`.
  - Next state is STEP if `imm8`≠0, otherwise DONE.
  - `start` is ignored in STEP and DONE; no queuing.
- STEP:
  - `reg_sel` = `priority_encoder(mask_q)`, `mem_addr` = `addr_q`, `step_valid`=1.
  - `mask_q` is never 0 in STEP, so the encoder's undefined all-zero case is unreachable.
  - On `mem_ready`=1:
    - Clear `mask_q[reg_sel]`.
    - `addr_q` += STRIDE, truncated to ADDR_W (wraps from 2^ADDR_W−1 to 0).
    - If the cleared mask is 0, go to DONE; otherwise stay in STEP.
  - On `mem_ready`=0, hold all outputs stable. Outputs are stall-safe.
- DONE: `done`=1 and `busy`=1 for exactly one cycle, then IDLE. `step_valid`=0.
- Transfer order is strictly ascending register index. Addresses are consecutive: base, base+STRIDE, …
- Reset values: state=IDLE, `mask_q`=0, `addr_q`=0, `is_store_q`=0. Every output is 0 (`busy`, `step_valid`, `reg_sel`, `mem_addr`, `reg_wr_en`, `mem_wr_en`, `done`, `wb_en`, `wb_addr`).
- Reset mid-instruction: abort immediately to IDLE. No `done` pulse; no enable stays asserted after `rst_n` falls.

## Timing
- `start` is accepted in cycle 0.
- With `mem_ready` held high and N set bits in `imm8`:
  - Transfers occur in cycles 1..N.
  - `done` is high in cycle N+1.
  - IDLE is reached at cycle N+2.
  - The earliest next `start` is sampled in cycle N+2.
- Zero mask: `done` in cycle 1; no transfer; no enable asserted.
- Each low cycle of `mem_ready` adds one cycle of latency.
- `reg_sel`, `mem_addr` and `mem_wr_en` are registered-state decodes.
- `reg_wr_en` combinationally depends on `mem_ready`.

## Configuration
- `LMSM_ADDR_WRITEBACK_EN` defined:
  - `wb_en`=1 in DONE; `wb_addr` = final `addr_q` = base + N·STRIDE (mod 2^ADDR_W).
  - This lets the datapath update the base register.
- Undefined: the `wb_en`/`wb_addr` ports and their logic are absent, and the block adds no base-update behaviour.

## Structure
- Shared package `lmsm_pkg`:
  - State encoding constants: IDLE=2'd0, STEP=2'd1, DONE=2'd2.
  - `LMSM_MASK_W`=8 and `LMSM_SEL_W`=3.
- One sub-module: the existing `priority_encoder`, instantiated on `mask_q`. No new sub-module.

## Test plan
- `imm8`=8'b1010_0101, `base_addr`=16'h0100, LM, `mem_ready`=1:
  - `reg_sel` 0,2,5,7 at addresses 0100,0101,0102,0103 in cycles 1–4.
  - `reg_wr_en` high each of those cycles; `done` in cycle 5.
- SM, `imm8`=8'h80, `mem_ready` low for 3 cycles, then high:
  - `reg_sel`=7 and `mem_wr_en`=1 held stable for 4 cycles.
  - `done` follows the next cycle.
- `imm8`=0: `done` in cycle 1; `step_valid`, `reg_wr_en` and `mem_wr_en` never asserted.
- `base_addr`=16'hFFFE, `imm8`=8'h0F: addresses FFFE, FFFF, 0000, 0001.
  - With the macro defined: `wb_addr`=16'h0002 with `wb_en` in DONE.
- `rst_n` pulsed low during the third transfer of `imm8`=8'hFF:
  - All outputs 0 while reset is asserted.
  - State is IDLE after release; no `done` pulse.
  - A fresh `start` works normally.
- `start` re-asserted while `busy`: ignored, and the latched mask and address are unchanged.
